// File: rtl/ls194_universal_shift.sv
// 74LS194-style universal shift register: hold, shift right, shift left, parallel load.
// Define LS194_PARITY_EN to add the combinational PAR output (XOR-reduction of Q).
module ls194_universal_shift #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S0,
  input  logic             S1,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [WIDTH-1:0] P,
`ifdef LS194_PARITY_EN
  output logic [WIDTH-1:0] Q,
  output logic             PAR
`else
  output logic [WIDTH-1:0] Q
`endif
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHR   = 2'b01,
    MODE_SHL   = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q_next;

  assign mode = mode_e'({S1, S0});

  // Next-state selection; shift right moves QA toward QD with DSR entering QA.
  always_comb begin
    q_next = Q;
    unique case (mode)
      MODE_HOLD: q_next = Q;
      MODE_SHR:  q_next = {Q[WIDTH-2:0], DSR};
      MODE_SHL:  q_next = {DSL, Q[WIDTH-1:1]};
      MODE_LOAD: q_next = P;
      default:   q_next = Q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Q <= RESET_VAL;
    end else begin
      Q <= q_next;
    end
  end

`ifdef LS194_PARITY_EN
  assign PAR = ^Q;
`endif

endmodule

// File: tb/tb_ls194_universal_shift.sv
// Directed bench for ls194_universal_shift; PAR checks compile in with LS194_PARITY_EN.
module tb_ls194_universal_shift;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             s0;
  logic             s1;
  logic             dsr;
  logic             dsl;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
`ifdef LS194_PARITY_EN
  logic             par;
`endif

  int checks;
  int errors;

  ls194_universal_shift #(
    .WIDTH    (WIDTH),
    .RESET_VAL(4'b0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .S0 (s0),
    .S1 (s1),
    .DSR(dsr),
    .DSL(dsl),
    .P  (p),
`ifdef LS194_PARITY_EN
    .Q  (q),
    .PAR(par)
`else
    .Q  (q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    s1 = m[1];
    s0 = m[0];
  endtask

  task automatic test_reset();
    rst = 1'b0; set_mode(2'b11); p = 4'b1010; dsr = 1'b0; dsl = 1'b0;
    tick();
    checks++;
    if (q !== 4'b1010) begin
      errors++; $display("FAIL reset_preload: got %b expected %b", q, 4'b1010);
    end
    rst = 1'b1; set_mode(2'b01); dsr = 1'b1;
    tick();
    checks++;
    if (q !== 4'b0000) begin
      errors++; $display("FAIL reset_value: got %b expected %b", q, 4'b0000);
    end
`ifdef LS194_PARITY_EN
    checks++;
    if (par !== 1'b0) begin
      errors++; $display("FAIL reset_par: got %b expected %b", par, 1'b0);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_load_hold();
    set_mode(2'b11); p = 4'b1011;
    tick();
    checks++;
    if (q !== 4'b1011) begin
      errors++; $display("FAIL load: got %b expected %b", q, 4'b1011);
    end
    set_mode(2'b00); p = 4'b0000; dsr = 1'b1; dsl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== 4'b1011) begin
        errors++; $display("FAIL hold_%0d: got %b expected %b", i, q, 4'b1011);
      end
    end
`ifdef LS194_PARITY_EN
    checks++;
    if (par !== 1'b1) begin
      errors++; $display("FAIL hold_par: got %b expected %b", par, 1'b1);
    end
`endif
  endtask

  // A reset pulse that starts and ends between edges must not be seen.
  task automatic test_rst_between_edges();
    set_mode(2'b00);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    checks++;
    if (q !== 4'b1011) begin
      errors++; $display("FAIL rst_glitch: got %b expected %b", q, 4'b1011);
    end
  endtask

  task automatic test_shift_right();
    logic [3:0] dsr_seq;
    logic [3:0] exp_q [4];
    dsr_seq = 4'b1101;
    exp_q[0] = 4'b0001; exp_q[1] = 4'b0010; exp_q[2] = 4'b0101; exp_q[3] = 4'b1011;
    rst = 1'b1; tick(); rst = 1'b0;
    set_mode(2'b01);
    for (int i = 0; i < 4; i++) begin
      dsr = dsr_seq[i];
      dsl = ~dsl;
      tick();
      checks++;
      if (q !== exp_q[i]) begin
        errors++; $display("FAIL shr_%0d: got %b expected %b", i, q, exp_q[i]);
      end
    end
  endtask

  task automatic test_shift_left();
    logic [3:0] exp_q [4];
    exp_q[0] = 4'b1100; exp_q[1] = 4'b1110; exp_q[2] = 4'b1111; exp_q[3] = 4'b1111;
    set_mode(2'b11); p = 4'b1000;
    tick();
    set_mode(2'b10); dsl = 1'b1; p = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      dsr = i[0];
      tick();
      checks++;
      if (q !== exp_q[i]) begin
        errors++; $display("FAIL shl_%0d: got %b expected %b", i, q, exp_q[i]);
      end
    end
    // Shift left with DSL=0 drains ones out of QA.
    dsl = 1'b0;
    tick();
    checks++;
    if (q !== 4'b0111) begin
      errors++; $display("FAIL shl_drain: got %b expected %b", q, 4'b0111);
    end
  endtask

  task automatic test_lfsr();
    logic [3:0] exp_q [15];
    exp_q[0]  = 4'b0010; exp_q[1]  = 4'b0100; exp_q[2]  = 4'b1001; exp_q[3]  = 4'b0011;
    exp_q[4]  = 4'b0110; exp_q[5]  = 4'b1101; exp_q[6]  = 4'b1010; exp_q[7]  = 4'b0101;
    exp_q[8]  = 4'b1011; exp_q[9]  = 4'b0111; exp_q[10] = 4'b1111; exp_q[11] = 4'b1110;
    exp_q[12] = 4'b1100; exp_q[13] = 4'b1000; exp_q[14] = 4'b0001;
    set_mode(2'b11); p = 4'b0001;
    tick();
    set_mode(2'b01);
    for (int i = 0; i < 15; i++) begin
      dsr = q[3] ^ q[2];
      tick();
      checks++;
      if (q !== exp_q[i] || q === 4'b0000) begin
        errors++; $display("FAIL lfsr_%0d: got %b expected %b", i + 1, q, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    rst = 1'b1; tick(); rst = 1'b0;
    set_mode(2'b01);
    dsr = 1'b1; tick();
    dsr = 1'b0; tick();
    dsr = 1'b1; tick();
    checks++;
    if (q !== 4'b0101) begin
      errors++; $display("FAIL mid_setup: got %b expected %b", q, 4'b0101);
    end
    rst = 1'b1; dsr = 1'b1;
    tick();
    checks++;
    if (q !== 4'b0000) begin
      errors++; $display("FAIL mid_reset: got %b expected %b", q, 4'b0000);
    end
    rst = 1'b0; set_mode(2'b01); dsr = 1'b1;
    tick();
    checks++;
    if (q !== 4'b0001) begin
      errors++; $display("FAIL mid_resume: got %b expected %b", q, 4'b0001);
    end
`ifdef LS194_PARITY_EN
    checks++;
    if (par !== 1'b1) begin
      errors++; $display("FAIL mid_par: got %b expected %b", par, 1'b1);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; s0 = 1'b0; s1 = 1'b0; dsr = 1'b0; dsl = 1'b0; p = '0;
    tick();
    test_reset();
    test_load_hold();
    test_rst_between_edges();
    test_shift_right();
    test_shift_left();
    test_lfsr();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
